// File: rtl/beamform_pkg.sv
// Shared types and constants for the delay-and-sum beamformer.
package beamform_pkg;
   localparam int NUM_MICS          = 4;
   localparam int DEFAULT_RECIP_Q16 = 3146;

   typedef logic signed [15:0] sample_t;
   typedef logic signed [15:0] delay_us_t;
   typedef logic signed [17:0] sum_t;

   typedef enum logic {FILL = 1'b0, RUN = 1'b1} ds_state_t;
endpackage

// File: rtl/mic_delay_line.sv
// Circular sample buffer: one write port, one registered read port (1 cycle) with write-first forwarding.
// No backpressure; a write and a read may occur every cycle.
module mic_delay_line
   import beamform_pkg::*;
#(
   parameter int DEPTH    = 64,
   parameter int SAMPLE_W = 16,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                       i_clk,
   input  logic                       i_wr_en,
   input  logic [AW-1:0]              i_wr_addr,
   input  logic signed [SAMPLE_W-1:0] i_wr_dat,
   input  logic [AW-1:0]              i_rd_addr,
   output logic signed [SAMPLE_W-1:0] o_rd_dat
);
   logic signed [SAMPLE_W-1:0] r_mem [DEPTH];
   logic signed [SAMPLE_W-1:0] r_rd_dat;

   // Zero delay reads the slot being written this cycle, so return the incoming sample.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_dat;
      end
      if (i_wr_en && (i_rd_addr == i_wr_addr)) begin
         r_rd_dat <= i_wr_dat;
      end else begin
         r_rd_dat <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_dat = r_rd_dat;
endmodule

// File: rtl/mic_delay_sum.sv
// Four-mic delay-and-sum: steering delays (us) -> sample offsets, aligned sum out 2 cycles after each frame.
// Fully pipelined, no backpressure. DS_AVG_EN defined: output is the mean (sum >>> 2) instead of the sum.
module mic_delay_sum
   import beamform_pkg::*;
#(
   parameter int DEPTH     = 64,
   parameter int RECIP_Q16 = DEFAULT_RECIP_Q16,
   parameter int SAMPLE_W  = 16
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       delay_valid_in,
   input  logic signed [15:0]         delay_1,
   input  logic signed [15:0]         delay_2,
   input  logic signed [15:0]         delay_3,
   input  logic signed [15:0]         delay_4,
   input  logic                       sample_valid_in,
   input  logic signed [SAMPLE_W-1:0] mic_1,
   input  logic signed [SAMPLE_W-1:0] mic_2,
   input  logic signed [SAMPLE_W-1:0] mic_3,
   input  logic signed [SAMPLE_W-1:0] mic_4,
   output logic                       sum_valid_out,
   output logic signed [17:0]         sum_out,
   output logic                       ready_out
);
   localparam int AW                   = $clog2(DEPTH);
   localparam logic signed [31:0] RECIP_S = 32'(RECIP_Q16);
   localparam logic signed [31:0] MAX_D   = 32'(DEPTH - 1);

   ds_state_t r_state, w_state_nxt;
   logic [AW-1:0] r_wr_ptr, r_fill_cnt;
   logic r_c1_vld, r_commit, r_s1_vld, r_sum_vld;
   sum_t r_sum, w_sum, w_sum_out;

   logic signed [31:0]         r_prod    [NUM_MICS];
   logic signed [31:0]         w_samp    [NUM_MICS];
   logic [AW-1:0]              w_clamp   [NUM_MICS];
   logic [AW-1:0]              r_pend    [NUM_MICS];
   logic [AW-1:0]              r_act     [NUM_MICS];
   logic [AW-1:0]              w_rd_addr [NUM_MICS];
   delay_us_t                  w_delay   [NUM_MICS];
   logic signed [SAMPLE_W-1:0] w_mic     [NUM_MICS];
   logic signed [SAMPLE_W-1:0] w_rd_dat  [NUM_MICS];

   assign w_delay = '{delay_1, delay_2, delay_3, delay_4};
   assign w_mic   = '{mic_1, mic_2, mic_3, mic_4};

   always_comb begin
      for (int i = 0; i < NUM_MICS; i++) begin
         w_samp[i] = r_prod[i] >>> 16;
         if (w_samp[i] < 0) begin
            w_clamp[i] = '0;
         end else if (w_samp[i] > MAX_D) begin
            w_clamp[i] = '1;
         end else begin
            w_clamp[i] = w_samp[i][AW-1:0];
         end
         w_rd_addr[i] = r_wr_ptr - r_act[i];
      end
   end

   // A new strobe during conversion squashes C2; active delays only change on frame-free cycles.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_c1_vld <= 1'b0;
         r_commit <= 1'b0;
         for (int i = 0; i < NUM_MICS; i++) begin
            r_prod[i] <= '0;
            r_pend[i] <= '0;
            r_act[i]  <= '0;
         end
      end else begin
         r_c1_vld <= delay_valid_in;
         for (int i = 0; i < NUM_MICS; i++) begin
            if (delay_valid_in) begin
               r_prod[i] <= 32'(w_delay[i]) * RECIP_S;
            end
            if (r_c1_vld && !delay_valid_in) begin
               r_pend[i] <= w_clamp[i];
            end
            if (r_commit && !sample_valid_in) begin
               r_act[i] <= r_pend[i];
            end
         end
         if (r_c1_vld && !delay_valid_in) begin
            r_commit <= 1'b1;
         end else if (!sample_valid_in) begin
            r_commit <= 1'b0;
         end
      end
   end

   for (genvar g = 0; g < NUM_MICS; g++) begin : g_line
      mic_delay_line #(
         .DEPTH    (DEPTH),
         .SAMPLE_W (SAMPLE_W)
      ) u_line (
         .i_clk     (clk_in),
         .i_wr_en   (sample_valid_in),
         .i_wr_addr (r_wr_ptr),
         .i_wr_dat  (w_mic[g]),
         .i_rd_addr (w_rd_addr[g]),
         .o_rd_dat  (w_rd_dat[g])
      );
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < NUM_MICS; i++) begin
         w_sum = w_sum + sum_t'(w_rd_dat[i]);
      end
`ifdef DS_AVG_EN
      w_sum_out = w_sum >>> 2;
`else
      w_sum_out = w_sum;
`endif
   end

   always_comb begin
      w_state_nxt = r_state;
      ready_out   = 1'b0;
      case (r_state)
         FILL: begin
            if (sample_valid_in && (r_fill_cnt == AW'(DEPTH - 1))) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            ready_out = 1'b1;
         end
         default: w_state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_wr_ptr   <= '0;
         r_fill_cnt <= '0;
         r_s1_vld   <= 1'b0;
         r_sum_vld  <= 1'b0;
         r_sum      <= '0;
      end else begin
         r_s1_vld  <= sample_valid_in && (r_state == RUN);
         r_sum_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_sum <= w_sum_out;
         end
         if (sample_valid_in) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_state == FILL) begin
               r_fill_cnt <= r_fill_cnt + 1'b1;
            end
         end
      end
   end

   assign sum_valid_out = r_sum_vld;
   assign sum_out       = r_sum;
endmodule

// File: tb/tb_mic_delay_sum.sv
// Bench for mic_delay_sum: frame-history reference model, directed steps plus randomized frames and delays.
module tb_mic_delay_sum;
   logic               clk_in = 1'b0;
   logic               rst_in;
   logic               delay_valid_in;
   logic signed [15:0] delay_1, delay_2, delay_3, delay_4;
   logic               sample_valid_in;
   logic signed [15:0] mic_1, mic_2, mic_3, mic_4;
   logic               sum_valid_out;
   logic signed [17:0] sum_out;
   logic               ready_out;

   always #5 clk_in = ~clk_in;

   mic_delay_sum dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .delay_valid_in  (delay_valid_in),
      .delay_1         (delay_1),
      .delay_2         (delay_2),
      .delay_3         (delay_3),
      .delay_4         (delay_4),
      .sample_valid_in (sample_valid_in),
      .mic_1           (mic_1),
      .mic_2           (mic_2),
      .mic_3           (mic_3),
      .mic_4           (mic_4),
      .sum_valid_out   (sum_valid_out),
      .sum_out         (sum_out),
      .ready_out       (ready_out)
   );

   int n_checks = 0;
   int n_err    = 0;
   int hist [4][4096];
   int nfr;
   int act [4];
   int alt [4];
   int exp0_q [$];
   int exp1_q [$];
   int obs_q  [$];

   always @(negedge clk_in) begin
      if (sum_valid_out) obs_q.push_back(int'(sum_out));
   end

   function automatic int us2samp(input int us);
      int s;
      if (us < 0) return 0;
      s = (us * 3146) / 65536;
      return (s > 63) ? 63 : s;
   endfunction

   function automatic int rnd_s16();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic chk(input string tag, input int obs, input int e0, input int e1);
      n_checks++;
      assert (obs === e0 || obs === e1) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, e0);
      end
   endtask

   task automatic model_reset();
      nfr = 0;
      for (int i = 0; i < 4; i++) begin
         act[i] = 0;
         alt[i] = 0;
      end
      obs_q.delete();
      exp0_q.delete();
      exp1_q.delete();
   endtask

   task automatic frame(input int a, input int b, input int c, input int d);
      int v [4];
      int s0, s1;
      v = '{a, b, c, d};
      mic_1 = 16'(a); mic_2 = 16'(b); mic_3 = 16'(c); mic_4 = 16'(d);
      sample_valid_in = 1'b1;
      @(posedge clk_in); #1;
      sample_valid_in = 1'b0;
      for (int i = 0; i < 4; i++) hist[i][nfr] = v[i];
      if (nfr >= 64) begin
         s0 = 0;
         s1 = 0;
         for (int i = 0; i < 4; i++) begin
            s0 += hist[i][nfr - act[i]];
            s1 += hist[i][nfr - alt[i]];
         end
`ifdef DS_AVG_EN
         s0 = s0 >>> 2;
         s1 = s1 >>> 2;
`endif
         exp0_q.push_back(s0);
         exp1_q.push_back(s1);
      end
      nfr++;
   endtask

   task automatic rnd_frame();
      frame(rnd_s16(), rnd_s16(), rnd_s16(), rnd_s16());
   endtask

   task automatic drive_delays(input int a, input int b, input int c, input int d);
      delay_1 = 16'(a); delay_2 = 16'(b); delay_3 = 16'(c); delay_4 = 16'(d);
   endtask

   task automatic set_delays(input int a, input int b, input int c, input int d);
      int u [4];
      u = '{a, b, c, d};
      drive_delays(a, b, c, d);
      delay_valid_in = 1'b1;
      @(posedge clk_in); #1;
      delay_valid_in = 1'b0;
      repeat (4) @(posedge clk_in);
      #1;
      for (int i = 0; i < 4; i++) begin
         act[i] = us2samp(u[i]);
         alt[i] = act[i];
      end
   endtask

   task automatic check_outputs(input string tag);
      repeat (4) @(posedge clk_in);
      #1;
      chk({tag, " count"}, obs_q.size(), exp0_q.size(), exp0_q.size());
      while (obs_q.size() > 0 && exp0_q.size() > 0) begin
         chk(tag, obs_q.pop_front(), exp0_q.pop_front(), exp1_q.pop_front());
      end
      obs_q.delete();
      exp0_q.delete();
      exp1_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd [4];
      int sum_1000;
      rst_in = 1'b1;
      delay_valid_in = 1'b0;
      sample_valid_in = 1'b0;
      drive_delays(0, 0, 0, 0);
      mic_1 = '0; mic_2 = '0; mic_3 = '0; mic_4 = '0;
      model_reset();
      #12;
      chk("reset sum_out", int'(sum_out), 0, 0);
      chk("reset sum_valid_out", int'(sum_valid_out), 0, 0);
      chk("reset ready_out", int'(ready_out), 0, 0);
      @(posedge clk_in); #1;
      rst_in = 1'b0;

      // Prime with zero delays, then a single frame with a fixed 2-cycle latency check.
      repeat (63) frame(0, 0, 0, 0);
      chk("ready after 63 frames", int'(ready_out), 0, 0);
      frame(0, 0, 0, 0);
      chk("ready after 64 frames", int'(ready_out), 1, 1);
      check_outputs("prime");
`ifdef DS_AVG_EN
      sum_1000 = 250;
`else
      sum_1000 = 1000;
`endif
      frame(100, 200, 300, 400);
      @(negedge clk_in);
      chk("latency T+1 valid", int'(sum_valid_out), 0, 0);
      @(negedge clk_in);
      chk("latency T+2 valid", int'(sum_valid_out), 1, 1);
      chk("basic sum", int'(sum_out), sum_1000, sum_1000);
      check_outputs("basic");

      // Impulse with 1- and 20-sample offsets.
      set_delays(0, 21, 0, 437);
      repeat (25) frame(0, 0, 0, 0);
      frame(1000, 1000, 1000, 1000);
      repeat (25) frame(0, 0, 0, 0);
      check_outputs("impulse");

      // Clamping: over-range delay -> 63 samples, negative -> 0.
      set_delays(2000, 0, -50, 0);
      repeat (64) frame(0, 0, 0, 0);
      frame(1000, 1000, 1000, 1000);
      repeat (66) frame(0, 0, 0, 0);
      check_outputs("clamp");

      // Back-to-back strobes: the later set must end up active.
      drive_delays(500, 500, 500, 500);
      delay_valid_in = 1'b1;
      @(posedge clk_in); #1;
      drive_delays(100, 300, 600, 900);
      @(posedge clk_in); #1;
      delay_valid_in = 1'b0;
      repeat (4) @(posedge clk_in);
      #1;
      act = '{us2samp(100), us2samp(300), us2samp(600), us2samp(900)};
      alt = act;
      repeat (70) rnd_frame();
      check_outputs("last strobe wins");

      // Delay update during a continuous stream: each output uses one whole set.
      for (int k = 0; k < 40; k++) begin
         if (k == 10) begin
            for (int i = 0; i < 4; i++) nd[i] = int'($urandom_range(0, 1400));
            drive_delays(nd[0], nd[1], nd[2], nd[3]);
            delay_valid_in = 1'b1;
            for (int i = 0; i < 4; i++) alt[i] = us2samp(nd[i]);
         end
         rnd_frame();
         delay_valid_in = 1'b0;
      end
      check_outputs("mixed stream");
      act = alt;
      repeat (30) rnd_frame();
      check_outputs("mixed after");

      // Ramp across the write-pointer wrap with a 10-sample delay.
      set_delays(209, 209, 209, 209);
      for (int n = 0; n < 200; n++) frame(n, n, n, n);
      check_outputs("wrap ramp");

      // Random delays and frames with random idle gaps.
      for (int r = 0; r < 4; r++) begin
         set_delays(int'($urandom_range(0, 1700)) - 100, int'($urandom_range(0, 1700)) - 100,
                    int'($urandom_range(0, 1700)) - 100, int'($urandom_range(0, 1700)) - 100);
         for (int k = 0; k < 40; k++) begin
            rnd_frame();
            repeat ($urandom_range(0, 2)) @(posedge clk_in);
            #1;
         end
         check_outputs("random");
      end

      // Asynchronous reset between edges with an output in flight.
      set_delays(0, 0, 0, 0);
      repeat (3) frame(500, 500, 500, 500);
      check_outputs("pre reset");
      frame(1, 2, 3, 4);
      @(negedge clk_in);
      #2 rst_in = 1'b1;
      #1;
      chk("midreset sum_out", int'(sum_out), 0, 0);
      chk("midreset sum_valid_out", int'(sum_valid_out), 0, 0);
      chk("midreset ready_out", int'(ready_out), 0, 0);
      model_reset();
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      repeat (63) rnd_frame();
      chk("post reset ready 63", int'(ready_out), 0, 0);
      rnd_frame();
      chk("post reset ready 64", int'(ready_out), 1, 1);
      check_outputs("post reset fill");
      repeat (10) rnd_frame();
      check_outputs("post reset run");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
